// File: rtl/urv_sys_arb.sv
// -----------------------------------------------------------------------------
// urv_sys_arb
// Shares the single CPU system bus between the dmem (0), imem (1) and
// icache-refill (2) requesters. A grant is held until the system side accepts
// it. Every accepted request pushes its requester index into an in-order FIFO.
// Responses are routed back to the requester at the FIFO head.
//
// Build option:
//   URV_SYS_ARB_RR_EN  defined   -> round-robin priority (search starts after
//                                   the last granted requester)
//                      undefined -> fixed priority, 0 > 1 > 2
//
// Ports:
//   clk, rstn                          clock, async active-low reset
//   m_req_valid/m_req_ready/m_req      per-requester request channel
//                                      (m_req is REQ_N packed REQ_W payloads)
//   m_resp_valid/m_resp_ready          per-requester response handshake
//   m_resp                             response payload, broadcast to all
//   sys_req_valid/ready/sys_req        system request channel
//   sys_resp_valid/ready/sys_resp      system response channel
//   ost_cnt                            number of outstanding requests
//   err_resp_unexp                     sticky: response seen while none pending
// -----------------------------------------------------------------------------
module urv_sys_arb #(
    parameter int REQ_N     = 3,
    parameter int OST_DEPTH = 4,
    parameter int REQ_W     = 32,
    parameter int RESP_W    = 32,
    localparam int IDX_W    = (REQ_N > 1) ? $clog2(REQ_N) : 1,
    localparam int PTR_W    = $clog2(OST_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [REQ_N-1:0]       m_req_valid,
    output logic [REQ_N-1:0]       m_req_ready,
    input  logic [REQ_N*REQ_W-1:0] m_req,
    output logic [REQ_N-1:0]       m_resp_valid,
    input  logic [REQ_N-1:0]       m_resp_ready,
    output logic [RESP_W-1:0]      m_resp,
    output logic                   sys_req_valid,
    input  logic                   sys_req_ready,
    output logic [REQ_W-1:0]       sys_req,
    input  logic                   sys_resp_valid,
    output logic                   sys_resp_ready,
    input  logic [RESP_W-1:0]      sys_resp,
    output logic [CNT_W-1:0]       ost_cnt,
    output logic                   err_resp_unexp
);

    logic             lock_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] fifo_r [OST_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] ost_cnt_r;
    logic             err_r;
`ifdef URV_SYS_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_r;
`endif

    logic             full_s;
    logic             empty_s;
    logic             grant_vld_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] head_idx_s;
    logic             push_s;
    logic             pop_s;

    assign full_s     = (ost_cnt_r == CNT_W'(OST_DEPTH));
    assign empty_s    = (ost_cnt_r == {CNT_W{1'b0}});
    assign head_idx_s = fifo_r[rd_ptr_r];

    // Grant selection: a held grant wins; otherwise search unless the FIFO is full.
    always_comb begin : grant_sel
        grant_vld_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        if (lock_r) begin
            grant_vld_s = 1'b1;
            grant_idx_s = lock_idx_r;
        end else if (!full_s) begin
`ifdef URV_SYS_ARB_RR_EN
            // Candidates in order rr_ptr+1, rr_ptr+2, ... wrapping at REQ_N.
            for (int k = 1; k <= REQ_N; k++) begin
                int cand;
                cand = int'(rr_ptr_r) + k;
                if (cand >= REQ_N) begin
                    cand = cand - REQ_N;
                end else begin
                    cand = cand;
                end
                if (!grant_vld_s && m_req_valid[IDX_W'(cand)]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = IDX_W'(cand);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
`else
            // Scan from the highest index down so the lowest valid index wins.
            for (int i = REQ_N - 1; i >= 0; i--) begin
                if (m_req_valid[IDX_W'(i)]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = IDX_W'(i);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
`endif
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    // Request and response routing (combinational, zero added latency).
    always_comb begin : route
        sys_req_valid  = grant_vld_s & m_req_valid[grant_idx_s];
        sys_req        = m_req[grant_idx_s*REQ_W +: REQ_W];
        m_req_ready    = {REQ_N{grant_vld_s & sys_req_ready}} & (REQ_N'(1'b1) << grant_idx_s);
        m_resp_valid   = {REQ_N{sys_resp_valid & !empty_s}} & (REQ_N'(1'b1) << head_idx_s);
        sys_resp_ready = m_resp_ready[head_idx_s] & !empty_s;
        m_resp         = sys_resp;
    end

    assign push_s = sys_req_valid & sys_req_ready;
    assign pop_s  = sys_resp_valid & sys_resp_ready;

    // Grant hold: lock onto a stalled request, release on its handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_r     <= 1'b0;
            lock_idx_r <= {IDX_W{1'b0}};
        end else if (push_s) begin
            lock_r     <= 1'b0;
            lock_idx_r <= lock_idx_r;
        end else if (sys_req_valid) begin
            lock_r     <= 1'b1;
            lock_idx_r <= grant_idx_s;
        end else begin
            lock_r     <= lock_r;
            lock_idx_r <= lock_idx_r;
        end
    end

    // Outstanding-order FIFO: pointers wrap naturally since OST_DEPTH is 2^n.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                fifo_r[i] <= {IDX_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Outstanding count: push and pop in the same cycle cancel out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ost_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   ost_cnt_r <= ost_cnt_r + CNT_W'(1'b1);
                2'b01:   ost_cnt_r <= ost_cnt_r - CNT_W'(1'b1);
                default: ost_cnt_r <= ost_cnt_r;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if (sys_resp_valid && empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

`ifdef URV_SYS_ARB_RR_EN
    // Round-robin pointer: remember the last requester that handshook.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_r <= IDX_W'(REQ_N - 1);
        end else if (push_s) begin
            rr_ptr_r <= grant_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    assign ost_cnt        = ost_cnt_r;
    assign err_resp_unexp = err_r;

endmodule

// File: doc/urv_sys_arb.md
# urv_sys_arb

Shares the single CPU system bus (`sys_req`/`sys_resp`) between the uncore's data-side (dmem), non-cacheable instruction (imem) and icache-refill requesters. Arbitrates requests, holds each grant until accepted, records the granted requester in an in-order outstanding FIFO, and routes each response back to its owner. It sits inside `urv_uncore`, between the dm/clint/plic address decode and the `sys_*` ports of `urv_cpu`.

## Interface
- `REQ_N`, 3, number of requesters; index 0 = dmem, 1 = imem, 2 = icache.
- `OST_DEPTH`, 4, maximum outstanding requests (power of two, ≥2).
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `m_req_valid`  in  REQ_N  per-requester request valid.
- `m_req_ready`  out  REQ_N  per-requester request ready.
- `m_req`  in  REQ_N × mem_req_t  per-requester request payload.
- `m_resp_valid`  out  REQ_N  per-requester response valid.
- `m_resp_ready`  in  REQ_N  per-requester response ready.
- `m_resp`  out  mem_resp_t  response payload, broadcast to all requesters and qualified by `m_resp_valid`.
- `sys_req_valid` / `sys_req_ready` / `sys_req`  out/in/out  1/1/mem_req_t  system request channel.
- `sys_resp_valid` / `sys_resp_ready` / `sys_resp`  in/out/in  1/1/mem_resp_t  system response channel.
- `ost_cnt`  out  $clog2(OST_DEPTH)+1  current outstanding count.
- `err_resp_unexp`  out  1  sticky flag: a response arrived while no request was outstanding.

## Operation
- State: `lock` (1b), `lock_idx`, `rr_ptr`, order FIFO (`OST_DEPTH` × $clog2(REQ_N)), `ost_cnt`, `err_resp_unexp`.
- Grant when `lock`=0 and `ost_cnt`<OST_DEPTH: pick the first valid requester by priority. When `lock`=1: grant = `lock_idx`.
- `sys_req_valid` = `m_req_valid[grant]` & a grant exists; `sys_req` = `m_req[grant]`; `m_req_ready[i]` = (i==grant) & `sys_req_ready`; all other readies are 0.
- Hold: if `sys_req_valid` & !`sys_req_ready`, set `lock`=1 and `lock_idx`=grant. Clear `lock` on handshake. Grants never switch while a request is pending.
- On request handshake: push the grant index into the FIFO, increment `ost_cnt`, and set `rr_ptr`=grant.
- Full: `ost_cnt`==OST_DEPTH blocks new grants, even when a pop happens in the same cycle. An existing `lock` is never set while full.
- Response routing: head = FIFO head index. `m_resp_valid[head]` = `sys_resp_valid` & !empty. `sys_resp_ready` = `m_resp_ready[head]` & !empty. `m_resp` = `sys_resp`.
- On response handshake: pop the FIFO and decrement `ost_cnt`. A simultaneous push and pop leaves `ost_cnt` unchanged.
- Empty: `sys_resp_ready`=0. If `sys_resp_valid`=1 while empty, set `err_resp_unexp`=1; it clears only on reset.
- FIFO pointers wrap modulo OST_DEPTH.
- Reset (any time, including mid-transaction): `lock`=0, FIFO empty, `ost_cnt`=0, `rr_ptr`=REQ_N-1, `err_resp_unexp`=0. In-flight transactions are discarded. The system side is reset by the same `rstn`.

## Timing
- Request path is combinational: a request seen in cycle N can handshake in cycle N with 0 added latency.
- Response path is combinational: 0 added latency.
- Reset values of outputs: `sys_req_valid`=0, `m_req_ready`=0, `m_resp_valid`=0, `sys_resp_ready`=0, `ost_cnt`=0, `err_resp_unexp`=0.
- A request accepted in cycle N is counted in `ost_cnt` from cycle N+1. Its response may handshake no earlier than cycle N+1.
- The priority pointer updates on the clock edge after a handshake.
- There is no combinational path from `m_req_valid` to `m_req_ready` of a different requester while `lock`=1.

## Configuration
- `URV_SYS_ARB_RR_EN` defined: round-robin priority. Search starts at (`rr_ptr`+1) mod REQ_N and wraps.
- `URV_SYS_ARB_RR_EN` undefined: fixed priority, index 0 (dmem) > 1 (imem) > 2 (icache). `rr_ptr` is not implemented.

## Test plan
- All three requesters valid continuously, `sys_req_ready`=1, RR on → grants 0,1,2,0,1,2. RR off → grants 0,0,0.
- Requester 2 valid, `sys_req_ready` low for 3 cycles while requester 0 raises valid → grant stays on 2 with stable payload. Requester 0 is granted the cycle after the handshake (RR).
- 4 requests accepted with no responses (OST_DEPTH=4) → `ost_cnt`=4 and 5th `sys_req_valid`=0. One response pops → the 5th request is granted on the next cycle.
- Interleaved requests 1,0,2 then three responses → `m_resp_valid` asserts to 1, 0, 2 in order. Holding `m_resp_ready[0]`=0 stalls `sys_resp_ready`.
- `sys_resp_valid`=1 with the FIFO empty → `sys_resp_ready`=0 and `err_resp_unexp`=1, held until `rstn` deasserts then reasserts.
- `rstn` asserted with 2 outstanding and a locked grant → next cycle `ost_cnt`=0, `lock`=0, all valid/ready outputs 0. RR restarts at index 0.
